// File: rtl/ovr_pkg.sv
// Shared defaults, FSM encoding and window helpers for the
// one-vs-rest class scheduler.
package ovr_pkg;

    localparam int NUM_CLASS = 10;
    localparam int N_FEAT    = 81;
    localparam int XW        = 7;
    localparam int HW        = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [XW-1:0] win_elem(
        input logic [N_FEAT*XW-1:0] w,
        input int unsigned          i
    );
        return w[i*XW +: XW];
    endfunction

endpackage

// File: rtl/ovr_class_scheduler_argmax_tracker.sv
// Running argmax over signed scores; strict greater-than so that
// ties keep the earliest (lowest) class index.
module argmax_tracker #(
    parameter int HW    = 32,
    parameter int CLS_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [HW-1:0]    score,
    input  logic [CLS_W-1:0] idx,
    output logic [HW-1:0]    nxt_score,
    output logic [CLS_W-1:0] nxt_cls
);
    import ovr_pkg::*;

    logic [HW-1:0]    best_score;
    logic [CLS_W-1:0] best_cls;
    logic             take;

    // clr forces the first class in unconditionally
    assign take = en && (clr || ($signed(score) > $signed(best_score)));

    assign nxt_score = take ? score : best_score;
    assign nxt_cls   = take ? idx   : best_cls;

    always_ff @(posedge clk) begin
        if (rst) begin
            best_score <= '0;
            best_cls   <= '0;
        end else begin
            best_score <= nxt_score;
            best_cls   <= nxt_cls;
        end
    end

endmodule

// File: rtl/ovr_class_scheduler.sv
// Time-multiplexes one shared inner-product datapath across all
// one-vs-rest weight sets and reports the highest scoring class.
module ovr_class_scheduler #(
    parameter  int NUM_CLASS = ovr_pkg::NUM_CLASS,
    parameter  int N_FEAT    = ovr_pkg::N_FEAT,
    parameter  int XW        = ovr_pkg::XW,
    parameter  int HW        = ovr_pkg::HW,
    parameter  int IP_LAT    = 0,
    localparam int CLS_W     = $clog2(NUM_CLASS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 win_valid,
    output logic                 win_ready,
    input  logic [N_FEAT*XW-1:0] win_x,
    output logic [N_FEAT*XW-1:0] ip_x,
    output logic [CLS_W-1:0]     ip_cls,
    input  logic [HW-1:0]        ip_hprime,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [CLS_W-1:0]     res_cls,
    output logic [HW-1:0]        res_score
);
    import ovr_pkg::*;

    localparam int WCW = (IP_LAT > 0) ? $clog2(IP_LAT + 1) : 1;
    localparam logic [CLS_W-1:0] LAST_CLS = CLS_W'(NUM_CLASS - 1);
    localparam logic [WCW-1:0]   LAST_W   = WCW'(IP_LAT);

    state_t           state;
    logic [WCW-1:0]   wcnt;
    logic             slot_end;
    logic             trk_en;
    logic [HW-1:0]    nxt_score;
    logic [CLS_W-1:0] nxt_cls;

    assign slot_end  = (wcnt == LAST_W);
    assign trk_en    = (state == EVAL) && slot_end;
    assign win_ready = (state == IDLE) && !rst;
    assign res_valid = (state == DONE);

    argmax_tracker #(
        .HW    (HW),
        .CLS_W (CLS_W)
    ) u_trk (
        .clk       (clk),
        .rst       (rst),
        .en        (trk_en),
        .clr       (ip_cls == '0),
        .score     (ip_hprime),
        .idx       (ip_cls),
        .nxt_score (nxt_score),
        .nxt_cls   (nxt_cls)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ip_x      <= '0;
            ip_cls    <= '0;
            wcnt      <= '0;
            res_cls   <= '0;
            res_score <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (win_valid) begin
                        ip_x   <= win_x;
                        ip_cls <= '0;
                        wcnt   <= '0;
                        state  <= EVAL;
                    end
                end
                EVAL: begin
                    if (slot_end) begin
                        wcnt <= '0;
                        // result registers only move when a full sweep lands
                        if (ip_cls == LAST_CLS) begin
                            res_cls   <= nxt_cls;
                            res_score <= nxt_score;
                            state     <= DONE;
                        end else begin
                            ip_cls <= ip_cls + CLS_W'(1);
                        end
                    end else begin
                        wcnt <= wcnt + WCW'(1);
                    end
                end
                DONE: begin
                    if (res_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ovr_class_scheduler.sv
// Scoreboard bench: two schedulers (IP_LAT 0 and 2) driven against
// a programmable per-class score model of the shared datapath.
module tb_ovr_class_scheduler;
    import ovr_pkg::*;

    localparam int CW = 4;
    localparam int WW = N_FEAT * XW;

    typedef logic signed [HW-1:0] sv_t [NUM_CLASS];
    typedef struct {
        logic [CW-1:0] cls;
        logic [HW-1:0] score;
        int            lat;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wv0 = 1'b0, wv1 = 1'b0;
    logic          rr0 = 1'b1, rr1 = 1'b1;
    logic [WW-1:0] wx0 = '0, wx1 = '0;
    logic          wr0, wr1, rv0, rv1;
    logic [WW-1:0] ipx0, ipx1;
    logic [CW-1:0] ipc0, ipc1, rc0, rc1;
    logic [HW-1:0] hp0, hp1, rs0, rs1;
    logic [HW-1:0] sc0 [16];
    logic [HW-1:0] sc1 [16];
    logic [CW-1:0] dl1, dl2;

    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    exp_t q0[$];
    exp_t q1[$];
    int   acc [2];
    bit   seen [2] = '{1'b1, 1'b1};

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        dl1 <= ipc1;
        dl2 <= dl1;
    end

    assign hp0 = sc0[ipc0];
    assign hp1 = sc1[dl2];

    ovr_class_scheduler #(.IP_LAT(0)) dut0 (
        .clk(clk), .rst(rst),
        .win_valid(wv0), .win_ready(wr0), .win_x(wx0),
        .ip_x(ipx0), .ip_cls(ipc0), .ip_hprime(hp0),
        .res_valid(rv0), .res_ready(rr0),
        .res_cls(rc0), .res_score(rs0)
    );

    ovr_class_scheduler #(.IP_LAT(2)) dut1 (
        .clk(clk), .rst(rst),
        .win_valid(wv1), .win_ready(wr1), .win_x(wx1),
        .ip_x(ipx1), .ip_cls(ipc1), .ip_hprime(hp1),
        .res_valid(rv1), .res_ready(rr1),
        .res_cls(rc1), .res_score(rs1)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int qsz(input int d);
        return (d != 0) ? q1.size() : q0.size();
    endfunction

    task automatic mon(input int d, input logic wv, input logic wr, input logic rv,
                       input logic rr, input logic [CW-1:0] rc, input logic [HW-1:0] rs);
        exp_t e;
        if (rst) begin
            seen[d] = 1'b1;
            return;
        end
        if (wv && wr) begin
            acc[d]  = cyc;
            seen[d] = 1'b0;
        end
        if (rv && !seen[d]) begin
            seen[d] = 1'b1;
            check($sformatf("pending%0d", d), 64'(qsz(d) != 0), 64'(1));
            if (qsz(d) != 0) begin
                e = (d != 0) ? q1[0] : q0[0];
                check($sformatf("latency%0d", d), 64'(cyc - acc[d]), 64'(e.lat));
            end
        end
        if (rv && rr && qsz(d) != 0) begin
            if (d != 0) e = q1.pop_front();
            else        e = q0.pop_front();
            check($sformatf("res_cls%0d", d), 64'(rc), 64'(e.cls));
            check($sformatf("res_score%0d", d), 64'(rs), 64'(e.score));
        end
    endtask

    always @(negedge clk) begin
        mon(0, wv0, wr0, rv0, rr0, rc0, rs0);
        mon(1, wv1, wr1, rv1, rr1, rc1, rs1);
    end

    function automatic logic [WW-1:0] mkpat(input int seed);
        logic [WW-1:0] p;
        for (int i = 0; i < N_FEAT; i++) p[i*XW +: XW] = XW'(i * 13 + seed);
        return p;
    endfunction

    task automatic push(input int d, input int ec, input int es);
        exp_t e;
        e.cls   = CW'(ec);
        e.score = HW'(es);
        e.lat   = 1 + NUM_CLASS * ((d != 0) ? 3 : 1);
        if (d != 0) q1.push_back(e);
        else        q0.push_back(e);
    endtask

    task automatic load(input int d, input sv_t s);
        for (int i = 0; i < NUM_CLASS; i++) begin
            if (d != 0) sc1[i] = s[i];
            else        sc0[i] = s[i];
        end
    endtask

    task automatic send(input int d, input sv_t s, input int ec, input int es, input bit do_push);
        logic [WW-1:0] pat;
        int            n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!((d != 0) ? wr1 : wr0) && n < 300);
        check("send_ready", 64'((d != 0) ? wr1 : wr0), 64'(1));
        pat = mkpat(ec * 7 + d);
        if (do_push) push(d, ec, es);
        load(d, s);
        if (d != 0) begin wv1 = 1'b1; wx1 = pat; end
        else        begin wv0 = 1'b1; wx0 = pat; end
        @(posedge clk);
        #1;
        wv0 = 1'b0;
        wv1 = 1'b0;
        check("ipx_e0", 64'(win_elem((d != 0) ? ipx1 : ipx0, 0)), 64'(win_elem(pat, 0)));
        check("ipx_e80", 64'(win_elem((d != 0) ? ipx1 : ipx0, 80)), 64'(win_elem(pat, 80)));
    endtask

    task automatic drain(input int d);
        int n;
        n = 0;
        while (qsz(d) != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("drain%0d", d), 64'(qsz(d)), 64'(0));
    endtask

    initial begin
        sv_t           s;
        logic [WW-1:0] pat2;
        int            n;
        for (int i = 0; i < 16; i++) begin
            sc0[i] = '0;
            sc1[i] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_wr", 64'(wr0), 64'(0));
        check("rst_rv", 64'(rv0), 64'(0));
        check("rst_rc", 64'(rc0), 64'(0));
        check("rst_rs", 64'(rs0), 64'(0));
        check("rst_ipc", 64'(ipc0), 64'(0));
        check("rst_ipx", 64'(ipx0 != '0), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_wr0", 64'(wr0), 64'(1));
        check("post_rst_wr1", 64'(wr1), 64'(1));

        s = '{5, -3, 20, 7, 0, 1, 2, 3, 4, 19};
        send(0, s, 2, 20, 1'b1);
        drain(0);
        s = '{-9, -8, -100, -1, -50, -7, -7, -7, -7, -2};
        send(0, s, 3, -1, 1'b1);
        drain(0);
        s = '{12, 12, 12, 12, 12, 12, 12, 12, 12, 12};
        send(0, s, 0, 12, 1'b1);
        drain(0);
        s = '{0, 4, 4, 1, 0, 0, 0, 0, 0, 0};
        send(0, s, 1, 4, 1'b1);
        drain(0);

        s = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 100};
        send(1, s, 9, 100, 1'b1);
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            check("lat2_hold", 64'(ipc1), 64'(k / 3));
        end
        drain(1);

        @(posedge clk);
        #1;
        rr0 = 1'b0;
        s = '{3, 1, 4, 1, 5, 9, 2, 6, 5, 3};
        send(0, s, 5, 9, 1'b1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rv0 && n < 100);
        check("bp_rise", 64'(rv0), 64'(1));
        @(posedge clk);
        #1;
        s = '{-5, -4, -3, -2, -1, -6, -7, -8, -9, -10};
        pat2 = mkpat(99);
        push(0, 4, -1);
        load(0, s);
        wv0 = 1'b1;
        wx0 = pat2;
        repeat (20) begin
            @(negedge clk);
            check("bp_rv", 64'(rv0), 64'(1));
            check("bp_cls", 64'(rc0), 64'(5));
            check("bp_score", 64'(rs0), 64'(9));
            check("bp_wr", 64'(wr0), 64'(0));
        end
        @(posedge clk);
        #1;
        rr0 = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("bp_accept_wr", 64'(wr0), 64'(1));
        check("bp_accept_rv", 64'(rv0), 64'(0));
        @(posedge clk);
        #1;
        wv0 = 1'b0;
        check("bp_ipx", 64'(win_elem(ipx0, 40)), 64'(win_elem(pat2, 40)));
        drain(0);

        s = '{100, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        send(0, s, 0, 100, 1'b0);
        n = 0;
        while (ipc0 != 4'd4 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("rst_slot4", 64'(ipc0), 64'(4));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_rv", 64'(rv0), 64'(0));
        check("abort_ipc", 64'(ipc0), 64'(0));
        check("abort_wr", 64'(wr0), 64'(1));
        check("abort_rc", 64'(rc0), 64'(0));
        check("abort_rs", 64'(rs0), 64'(0));
        repeat (20) begin
            @(negedge clk);
            check("abort_quiet", 64'(rv0), 64'(0));
        end

        s = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
        send(0, s, 9, 10, 1'b1);
        drain(0);
        drain(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ovr_class_scheduler.md
# ovr_class_scheduler

Sequences one shared 81-tap inner-product datapath across NUM_CLASS one-vs-rest logistic-regression weight sets for a single 9x9 7-bit pixel window. The datapath returns hprime for each class, and the block reports the class with the largest score. It sits between the line-buffer window extractor and the classification result sink. It time-multiplexes one multiplier/adder tree instead of instantiating NUM_CLASS copies.

## Interface
Parameters:
- NUM_CLASS, 10, number of weight sets (classes); CLS_W = $clog2(NUM_CLASS).
- N_FEAT, 81, window elements.
- XW, 7, pixel width.
- HW, 32, hprime/score width, two's complement.
- IP_LAT, 0, register stages inside the shared datapath between cls_sel/x_out change and valid hprime.

Ports:
- clk, in, 1, sole clock, rising edge.
- rst, in, 1, synchronous active-high reset.
- win_valid, in, 1, window present on win_x.
- win_ready, out, 1, block can accept a window.
- win_x, in, N_FEAT*XW, packed window; element i at bits [i*XW +: XW].
- ip_x, out, N_FEAT*XW, registered window driven to the shared datapath.
- ip_cls, out, CLS_W, weight-set select driven to the datapath.
- ip_hprime, in, HW, datapath result for the current ip_cls/ip_x.
- res_valid, out, 1, result available.
- res_ready, in, 1, sink accepts result.
- res_cls, out, CLS_W, winning class index.
- res_score, out, HW, winning hprime.

## Operation
- States: IDLE, EVAL, DONE.
- IDLE:
  - win_ready=1.
  - On win_valid&&win_ready: capture win_x into ip_x, clear ip_cls=0, clear the wait counter, go to EVAL.
- EVAL:
  - Each class occupies a slot of IP_LAT+1 cycles. ip_cls is stable across the slot.
  - In the last cycle of the slot, sample ip_hprime as a signed value.
    - Class 0: loads best_score/best_cls unconditionally.
    - Class k>0: replaces the best only if ip_hprime > best_score, strictly signed. Ties keep the lower index.
  - After sampling class NUM_CLASS-1, go to DONE. Otherwise increment ip_cls and restart the slot.
- DONE:
  - res_valid=1; res_cls and res_score hold the best.
  - On res_ready, go to IDLE, with res_valid low the next cycle.
  - res_cls and res_score hold their values until the next result loads; only res_valid qualifies them.
- ip_x is held constant from capture until the next accepted window, so the datapath sees a stable window for every slot.
- No overflow handling. ip_hprime is compared as delivered; wrapping inside the datapath is the datapath's concern.

## Timing
- Reset values: win_ready=0 during rst, 1 the cycle after; res_valid=0; res_cls=0; res_score=0; ip_cls=0; ip_x=0; state=IDLE.
- Accept at edge T:
  - EVAL runs from T+1.
  - res_valid rises at T+1+NUM_CLASS*(IP_LAT+1).
  - With defaults, that is T+11.
- Throughput: one window per NUM_CLASS*(IP_LAT+1)+2 cycles minimum. This includes one DONE cycle with res_ready=1 and one IDLE accept cycle.
- win_ready is low in EVAL and DONE. No window is accepted while a result is pending, so there is no overlap.
- res_ready asserted before res_valid has no effect.
- Backpressure: DONE persists indefinitely with stable outputs.
- rst asserted in any state:
  - Next cycle is IDLE with all reset values.
  - The partial evaluation is discarded and no result is emitted.

## Structure
- Shared package ovr_pkg holds:
  - NUM_CLASS, N_FEAT, XW, HW defaults;
  - the state enum {IDLE, EVAL, DONE};
  - a function unpacking element i from the packed window.
- One natural sub-module: argmax_tracker. It takes a clear/load strobe plus a signed score and index, and holds best_score/best_cls with strict-greater, lower-index-wins semantics.
- The slot counter and FSM live in the top.

## Test plan
All scenarios use a bench datapath model that returns a programmed score per ip_cls after IP_LAT cycles.
- Scores {5,-3,20,7,0,1,2,3,4,19}, IP_LAT=0, res_ready=1 -> res_cls=2, res_score=20, res_valid rises exactly 11 cycles after accept.
- All scores negative {-9,-8,-100,-1,-50,-7,-7,-7,-7,-2} -> res_cls=3, res_score=-1. This confirms the signed compare and the class-0 unconditional load.
- Ties: scores {12,12,...,12} -> res_cls=0. Scores {0,4,4,1,...} -> res_cls=1.
- IP_LAT=2, scores {0,...,0,100 at class 9} -> res_cls=9. Each ip_cls is held for 3 cycles, and res_valid rises 31 cycles after accept.
- Backpressure and reset:
  - Hold res_ready=0 for 20 cycles -> res_valid, res_cls, res_score stable and win_ready=0. Release -> a new window is accepted one cycle later.
  - Assert rst at EVAL slot 4 -> next cycle IDLE, res_valid=0, ip_cls=0, and no result is emitted.
